// File: rtl/alu_md.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per clock, with single-edge fast paths for divide-by-zero and signed overflow.
module alu_md #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0]   ONE      = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE2     = (2*XLEN)'(1);
  localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]     LAST     = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  state_t            r_state;
  op_t               r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid;

  op_t               w_op;
  logic              w_s1_signed, w_s2_signed, w_s1_neg, w_s2_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_ovf;
  logic [XLEN-1:0]   w_special;
  logic [XLEN:0]     w_sum, w_shift, w_diff;
  logic [2*XLEN-1:0] w_acc_next, w_prod;
  logic [XLEN-1:0]   w_div_mag, w_div_res, w_final;

  // Operand decode and magnitudes, evaluated on the raw request inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_op        = op_t'(op);
    w_s1_signed = 1'b0;
    w_s2_signed = 1'b0;
    case (w_op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin w_s1_signed = 1'b1; w_s2_signed = 1'b1; end
      OP_MULHSU:                       w_s1_signed = 1'b1;
      default:                         ;
    endcase
    w_s1_neg   = w_s1_signed & src1[XLEN-1];
    w_s2_neg   = w_s2_signed & src2[XLEN-1];
    w_a_mag    = w_s1_neg ? (~src1 + ONE) : src1;
    w_b_mag    = w_s2_neg ? (~src2 + ONE) : src2;
    w_div_zero = op[2] & (src2 == '0);
    w_ovf      = (w_op == OP_DIV || w_op == OP_REM) && (src1 == MOST_NEG) && (src2 == '1);
    w_special  = '0;
    if (w_div_zero)  w_special = op[1] ? src1 : '1;
    else if (w_ovf)  w_special = op[1] ? '0 : src1;
  end

  // One iteration of the datapath plus final sign fix-up on the post-iteration value.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_shift = r_acc[2*XLEN-1:XLEN-1];
    w_diff  = w_shift - {1'b0, r_b};
    if (r_op[2])
      w_acc_next = w_diff[XLEN] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                : {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
    else
      w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    w_prod    = r_neg ? (~w_acc_next + ONE2) : w_acc_next;
    w_div_mag = r_op[1] ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
    w_div_res = r_neg ? (~w_div_mag + ONE) : w_div_mag;
    case (r_op)
      OP_MUL:                        w_final = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod[2*XLEN-1:XLEN];
      default:                       w_final = w_div_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, so a reset mid-operation leaves nothing stale visible.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_MUL;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (kill) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op  <= w_op;
          r_a   <= w_a_mag;
          r_b   <= w_b_mag;
          r_acc <= {{XLEN{1'b0}}, (op[2] ? w_a_mag : w_b_mag)};
          r_neg <= (op[2] & op[1]) ? w_s1_neg : (w_s1_neg ^ w_s2_neg);
          r_cnt <= '0;
          if (w_div_zero || w_ovf) begin
            r_result    <= w_special;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          if (r_cnt == LAST) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule
